// File: rtl/instr_trace_buf_if.sv
// Bundle of capture, browse-control and display signals of the instruction trace buffer.
// master drives capture/browse controls; slave is the trace buffer itself.
interface instr_trace_buf_if #(
    parameter int unsigned AW = 3
);
    logic        ir_write;
    logic [31:0] pc;
    logic [31:0] fetch_word;
    logic        clr;
    logic        freeze;
    logic        rd_step;
    logic [1:0]  rd_sel;
    logic [15:0] disp_word;
    logic        rd_valid;
    logic [AW:0] count;
    logic        overflow;
    logic [15:0] instr_cnt;

    modport master (
        output ir_write, pc, fetch_word, clr, freeze, rd_step, rd_sel,
        input  disp_word, rd_valid, count, overflow, instr_cnt
    );

    modport slave (
        input  ir_write, pc, fetch_word, clr, freeze, rd_step, rd_sel,
        output disp_word, rd_valid, count, overflow, instr_cnt
    );
endinterface

// File: rtl/instr_trace_buf.sv
// Circular trace of {pc, fetch_word} per fetch, browsable while frozen, shown on a 16-bit display.
// Optional TRACE_CYCLE_CNT_EN adds a per-entry fetch-to-fetch cycle count shown on rd_sel 11.
module instr_trace_buf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input logic              clk_cpu,
    input logic              rst_cpu,
    instr_trace_buf_if.slave bus
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [63:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   instr_cnt_q, instr_cnt_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic          freeze_q;
    logic [15:0]   disp_q, disp_d;
    logic          rd_valid_q, rd_valid_d;

    logic          capture;
    logic          freeze_rise;
    logic [AW-1:0] eff_idx;
    logic [AW-1:0] rd_addr;
    logic [63:0]   entry;
    logic [15:0]   field;
    logic          unused_pc_hi;

    assign capture     = bus.ir_write & ~bus.freeze & ~bus.clr;
    assign freeze_rise = bus.freeze & ~freeze_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        instr_cnt_d = instr_cnt_q;
        rd_idx_d    = rd_idx_q;
        if (bus.clr) begin
            wr_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            instr_cnt_d = '0;
            rd_idx_d    = '0;
        end else begin
            if (capture) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (count_q == FULL) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + (AW + 1)'(1);
                end
            end
            // Fetches are counted even while capture is frozen.
            if (bus.ir_write) begin
                instr_cnt_d = instr_cnt_q + 16'd1;
            end
            if (freeze_rise) begin
                rd_idx_d = '0;
            end else if (bus.freeze && bus.rd_step && (count_q != '0)) begin
                rd_idx_d = (({1'b0, rd_idx_q} + (AW + 1)'(1)) == count_q) ? '0
                                                                         : rd_idx_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_cpu or posedge rst_cpu) begin
        if (rst_cpu) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            instr_cnt_q <= '0;
            rd_idx_q    <= '0;
            freeze_q    <= 1'b0;
            disp_q      <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            instr_cnt_q <= instr_cnt_d;
            rd_idx_q    <= rd_idx_d;
            freeze_q    <= bus.freeze;
            disp_q      <= disp_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (capture) begin
            mem[wr_ptr_q] <= {bus.pc, bus.fetch_word};
        end
    end

`ifdef TRACE_CYCLE_CNT_EN
    logic [7:0] cyc_q, cyc_d;
    logic [7:0] cyc_mem [DEPTH];

    always_comb begin
        cyc_d = cyc_q;
        if (bus.clr) begin
            cyc_d = '0;
        end else if (capture) begin
            cyc_d = 8'd1;
        end else if (cyc_q != 8'hFF) begin
            cyc_d = cyc_q + 8'd1;
        end
    end

    always_ff @(posedge clk_cpu or posedge rst_cpu) begin
        if (rst_cpu) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (capture) begin
            cyc_mem[wr_ptr_q] <= cyc_q;
        end
    end
`endif

    // Live view always shows the newest entry; browse index only applies while frozen.
    assign eff_idx      = bus.freeze ? rd_idx_q : '0;
    assign rd_addr      = wr_ptr_q - AW'(1) - eff_idx;
    assign entry        = mem[rd_addr];
    assign unused_pc_hi = ^entry[63:48];

    always_comb begin
        rd_valid_d = ({1'b0, eff_idx} < count_q);
        field      = '0;
        disp_d     = '0;
        unique case (bus.rd_sel)
            2'b00: field = entry[47:32];
            2'b01: field = entry[15:0];
            2'b10: field = entry[31:16];
            default: field = '0;
        endcase
        if (bus.rd_sel == 2'b11) begin
`ifdef TRACE_CYCLE_CNT_EN
            disp_d = {rd_valid_d ? cyc_mem[rd_addr] : 8'h00, instr_cnt_q[7:0]};
`else
            disp_d = instr_cnt_q;
`endif
        end else if (rd_valid_d) begin
            disp_d = field;
        end
    end

    assign bus.disp_word = disp_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_instr_trace_buf.sv
// Directed table-driven bench for instr_trace_buf, plus hand sequences for async reset and rd_sel 11.
module tb_instr_trace_buf;

    typedef struct {
        string       name;
        logic        ir_write;
        logic [31:0] pc;
        logic [31:0] fw;
        logic        clr;
        logic        freeze;
        logic        rd_step;
        logic [1:0]  sel;
        logic [15:0] e_disp;
        logic        e_valid;
        logic [3:0]  e_count;
        logic        e_ovf;
        logic [15:0] e_icnt;
    } vec_t;

    logic clk_cpu = 1'b0;
    logic rst_cpu = 1'b1;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[$];

    always #5 clk_cpu = ~clk_cpu;

    instr_trace_buf_if #(.AW(3)) bus ();

    instr_trace_buf #(
        .DEPTH(8),
        .AW   (3)
    ) dut (
        .clk_cpu(clk_cpu),
        .rst_cpu(rst_cpu),
        .bus    (bus)
    );

    function automatic vec_t mk(string nm, logic irw, logic [31:0] pc, logic [31:0] fw,
                                logic clr, logic frz, logic step, logic [1:0] sel,
                                logic [15:0] ed, logic ev, logic [3:0] ec, logic eo,
                                logic [15:0] ei);
        vec_t v;
        v.name = nm; v.ir_write = irw; v.pc = pc; v.fw = fw; v.clr = clr; v.freeze = frz;
        v.rd_step = step; v.sel = sel; v.e_disp = ed; v.e_valid = ev; v.e_count = ec;
        v.e_ovf = eo; v.e_icnt = ei;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_all(string nm, logic [15:0] ed, logic ev, logic [3:0] ec, logic eo,
                             logic [15:0] ei);
        check({nm, ".disp"}, 32'(bus.disp_word), 32'(ed));
        check({nm, ".valid"}, 32'(bus.rd_valid), 32'(ev));
        check({nm, ".count"}, 32'(bus.count), 32'(ec));
        check({nm, ".ovf"}, 32'(bus.overflow), 32'(eo));
        check({nm, ".icnt"}, 32'(bus.instr_cnt), 32'(ei));
    endtask

    // One active cycle with the vector's inputs, one quiet cycle, then compare.
    task automatic apply_vec(vec_t v);
        bus.ir_write = v.ir_write; bus.pc = v.pc; bus.fetch_word = v.fw; bus.clr = v.clr;
        bus.freeze = v.freeze; bus.rd_step = v.rd_step; bus.rd_sel = v.sel;
        @(posedge clk_cpu); #1;
        bus.ir_write = 1'b0; bus.clr = 1'b0; bus.rd_step = 1'b0;
        @(posedge clk_cpu); #1;
        check_all(v.name, v.e_disp, v.e_valid, v.e_count, v.e_ovf, v.e_icnt);
    endtask

    initial begin
        bus.ir_write = 1'b0; bus.pc = '0; bus.fetch_word = '0; bus.clr = 1'b0;
        bus.freeze = 1'b0; bus.rd_step = 1'b0; bus.rd_sel = 2'b00;

        // Test 1: three captures then freeze.
        vecs.push_back(mk("t1_cap0", 1, 32'h0, 32'h8C010014, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 1));
        vecs.push_back(mk("t1_cap1", 1, 32'h4, 32'hAC020018, 0, 0, 0, 0, 16'h0004, 1, 2, 0, 2));
        vecs.push_back(mk("t1_cap2", 1, 32'h8, 32'h10220002, 0, 0, 0, 0, 16'h0008, 1, 3, 0, 3));
        vecs.push_back(mk("t1_frz", 0, 0, 0, 0, 1, 0, 0, 16'h0008, 1, 3, 0, 3));
        // Test 2: browse IR high half with wrap, then IR low half.
        vecs.push_back(mk("t2_ir_hi", 0, 0, 0, 0, 1, 0, 2, 16'h1022, 1, 3, 0, 3));
        vecs.push_back(mk("t2_step1", 0, 0, 0, 0, 1, 1, 2, 16'hAC02, 1, 3, 0, 3));
        vecs.push_back(mk("t2_step2", 0, 0, 0, 0, 1, 1, 2, 16'h8C01, 1, 3, 0, 3));
        vecs.push_back(mk("t2_wrap", 0, 0, 0, 0, 1, 1, 2, 16'h1022, 1, 3, 0, 3));
        vecs.push_back(mk("t2_ir_lo", 0, 0, 0, 0, 1, 0, 1, 16'h0002, 1, 3, 0, 3));
        // Test 3: overfill an 8-entry buffer, then browse to the oldest and wrap.
        vecs.push_back(mk("t3_clr", 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk($sformatf("t3_cap%0d", i), 1, 32'(4 * i), 32'hA0000000 | 32'(i),
                              0, 0, 0, 0, 16'(4 * i), 1, (i + 1 > 8) ? 4'd8 : 4'(i + 1),
                              (i >= 8), 16'(i + 1)));
        end
        vecs.push_back(mk("t3_frz", 0, 0, 0, 0, 1, 0, 0, 16'h0024, 1, 8, 1, 10));
        for (int k = 1; k <= 7; k++) begin
            vecs.push_back(mk($sformatf("t3_step%0d", k), 0, 0, 0, 0, 1, 1, 0,
                              16'(4 * (9 - k)), 1, 8, 1, 10));
        end
        vecs.push_back(mk("t3_wrap", 0, 0, 0, 0, 1, 1, 0, 16'h0024, 1, 8, 1, 10));
        // Test 4: frozen fetches, clr vs ir_write, step on empty, freeze-edge priority.
        vecs.push_back(mk("t4_frz_irw1", 1, 32'h100, 0, 0, 1, 0, 0, 16'h0024, 1, 8, 1, 11));
        vecs.push_back(mk("t4_frz_irw2", 1, 32'h104, 0, 0, 1, 0, 0, 16'h0024, 1, 8, 1, 12));
        vecs.push_back(mk("t4_clr_irw", 1, 32'h108, 0, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk("t4_step_empty", 0, 0, 0, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk("t4_cap40", 1, 32'h40, 32'h1, 0, 0, 0, 0, 16'h0040, 1, 1, 0, 1));
        vecs.push_back(mk("t4_cap44", 1, 32'h44, 32'h2, 0, 0, 0, 0, 16'h0044, 1, 2, 0, 2));
        vecs.push_back(mk("t4_rise_step", 0, 0, 0, 0, 1, 1, 0, 16'h0044, 1, 2, 0, 2));
        vecs.push_back(mk("t4_step", 0, 0, 0, 0, 1, 1, 0, 16'h0040, 1, 2, 0, 2));
        vecs.push_back(mk("t5_clr", 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk($sformatf("t5_cap%0d", i), 1, 32'h80 + 32'(4 * i), 32'h0, 0, 0,
                              0, 0, 16'h0080 + 16'(4 * i), 1, 4'(i + 1), 0, 16'(i + 1)));
        end

        #12;
        check_all("reset", 16'h0000, 0, 0, 0, 16'h0000);
        rst_cpu = 1'b0;
        @(posedge clk_cpu); #1;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Test 5: asynchronous reset between edges clears outputs without a clock.
        #3 rst_cpu = 1'b1;
        #1 check_all("t5_async_rst", 16'h0000, 0, 0, 0, 16'h0000);
        #2 rst_cpu = 1'b0;
        bus.ir_write = 1'b1; bus.pc = 32'h20; bus.fetch_word = 32'h0;
        @(posedge clk_cpu); #1;
        bus.ir_write = 1'b0;
        @(posedge clk_cpu); #1;
        check_all("t5_after_rst", 16'h0020, 1, 1, 0, 16'h0001);

        // Test 6: two captures five cycles apart, then rd_sel 11.
        bus.clr = 1'b1;
        @(posedge clk_cpu); #1;
        bus.clr = 1'b0; bus.ir_write = 1'b1; bus.pc = 32'h200;
        @(posedge clk_cpu); #1;
        bus.ir_write = 1'b0;
        repeat (4) @(posedge clk_cpu);
        #1 bus.ir_write = 1'b1; bus.pc = 32'h204;
        @(posedge clk_cpu); #1;
        bus.ir_write = 1'b0; bus.freeze = 1'b1; bus.rd_sel = 2'b11;
        @(posedge clk_cpu); #1;
        @(posedge clk_cpu); #1;
`ifdef TRACE_CYCLE_CNT_EN
        check_all("t6_sel11", 16'h0502, 1, 2, 0, 16'h0002);
`else
        check_all("t6_sel11", 16'h0002, 1, 2, 0, 16'h0002);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
